// File: rtl/sprite_pkg.sv
// Shared types and sizing helpers for the parametrised sprite renderer.
// The optional collision detector is enabled with SPRITE_RENDERER_COLLIDE_EN.
package sprite_pkg;

  localparam int unsigned DEF_SPRITE_W = 16;
  localparam int unsigned DEF_SPRITE_H = 16;
  localparam int unsigned DEF_ROM_W    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLoad,
    StSetup,
    StFetch,
    StWaitHstart,
    StDraw
  } state_e;

  function automatic int unsigned sprite_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter widths never collapse to zero bits.
  function automatic int unsigned sprite_clog2_min1(input int unsigned v);
    return (sprite_clog2(v) == 0) ? 1 : sprite_clog2(v);
  endfunction

endpackage

// File: rtl/sprite_renderer_p_if.sv
// Control/ROM/pixel bundle between object controller, sprite renderer and colour mux.
// playfield/collision exist only when SPRITE_RENDERER_COLLIDE_EN is defined.
interface sprite_renderer_p_if
  import sprite_pkg::*;
#(
  parameter int unsigned ADDR_W = sprite_clog2(DEF_SPRITE_H) + sprite_clog2(DEF_SPRITE_W / DEF_ROM_W),
  parameter int unsigned ROM_W  = DEF_ROM_W
);
  logic              vstart;
  logic              load;
  logic              hstart;
  logic              hmirror;
  logic              vmirror;
  logic              xscale;
  logic [ADDR_W-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_bits;
  logic              gfx;
  logic              busy;
  logic              done;
`ifdef SPRITE_RENDERER_COLLIDE_EN
  logic              playfield;
  logic              collision;

  modport master (
    output vstart, load, hstart, hmirror, vmirror, xscale, rom_bits, playfield,
    input  rom_addr, gfx, busy, done, collision
  );
  modport slave (
    input  vstart, load, hstart, hmirror, vmirror, xscale, rom_bits, playfield,
    output rom_addr, gfx, busy, done, collision
  );
`else
  modport master (
    output vstart, load, hstart, hmirror, vmirror, xscale, rom_bits,
    input  rom_addr, gfx, busy, done
  );
  modport slave (
    input  vstart, load, hstart, hmirror, vmirror, xscale, rom_bits,
    output rom_addr, gfx, busy, done
  );
`endif
endinterface

// File: rtl/sprite_line_buffer.sv
// One-scanline pixel store: word-wise loader plus mirrored, optionally 2x-stretched pixel walker.
module sprite_line_buffer
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W = DEF_SPRITE_W,
  parameter int unsigned ROM_W    = DEF_ROM_W,
  localparam int unsigned WORDS   = SPRITE_W / ROM_W,
  localparam int unsigned WB      = sprite_clog2_min1(WORDS),
  localparam int unsigned XB      = sprite_clog2(SPRITE_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WB-1:0]    i_word,
  input  logic [ROM_W-1:0] i_rom_bits,
  input  logic             i_clr,
  input  logic             i_step,
  input  logic             i_xscale,
  input  logic             i_hmirror,
  output logic             o_pix,
  output logic             o_last
);

  logic [SPRITE_W-1:0] r_bits;
  logic [XB-1:0]       r_x;
  logic                r_phase;
  logic                w_adv;

  // x advances every clock, or every second clock when stretched.
  assign w_adv = !i_xscale || r_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bits  <= '0;
      r_x     <= '0;
      r_phase <= 1'b0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (i_load && (i_word == WB'(i))) r_bits[i*ROM_W +: ROM_W] <= i_rom_bits;
      end
      if (i_clr) begin
        r_x     <= '0;
        r_phase <= 1'b0;
      end else if (i_step) begin
        if (w_adv) r_x <= r_x + 1'b1;
        if (i_xscale) r_phase <= ~r_phase;
      end
    end
  end

  // SPRITE_W is a power of two, so SPRITE_W-1-x is simply ~x.
  assign o_pix  = r_bits[i_hmirror ? ~r_x : r_x];
  assign o_last = (r_x == {XB{1'b1}}) && w_adv;

endmodule

// File: rtl/sprite_renderer_p.sv
// Per-scanline sprite fetch/draw sequencer driving an external ROM and the pixel output.
// Collision detection is added when SPRITE_RENDERER_COLLIDE_EN is defined.
module sprite_renderer_p
  import sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H = DEF_SPRITE_H,
  parameter int unsigned ROM_W    = DEF_ROM_W
) (
  input logic               clk,
  input logic               reset,
  sprite_renderer_p_if.slave bus
);

  localparam int unsigned WORDS  = SPRITE_W / ROM_W;
  localparam int unsigned RB     = sprite_clog2(SPRITE_H);
  localparam int unsigned CW     = sprite_clog2(WORDS);
  localparam int unsigned WB     = sprite_clog2_min1(WORDS);
  localparam int unsigned ADDR_W = RB + CW;

  state_e              r_state, w_state_d;
  logic [RB-1:0]       r_row, w_row_d, w_row_eff;
  logic [WB-1:0]       r_word, w_word_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d, w_addr_set;
  logic                r_gfx, w_gfx_d;
  logic                r_done, w_done_d;
  logic                r_hm, r_vm, r_xs;
  logic                w_latch, w_lb_load, w_lb_clr, w_lb_step, w_pix, w_last;

  // vmirror inverts only the fetched row; r_row itself always counts upward.
  assign w_row_eff = r_vm ? ~r_row : r_row;

  if (CW == 0) begin : g_one_word
    assign w_addr_set = w_row_eff;
  end else begin : g_multi_word
    assign w_addr_set = {w_row_eff, r_word};
  end

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_word_d  = r_word;
    w_addr_d  = r_addr;
    w_gfx_d   = 1'b0;
    w_done_d  = 1'b0;
    w_latch   = 1'b0;
    w_lb_load = 1'b0;
    w_lb_clr  = 1'b0;
    w_lb_step = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_row_d = '0;
        if (bus.vstart) begin
          w_latch   = 1'b1;
          w_state_d = StWaitLoad;
        end
      end
      StWaitLoad: begin
        w_word_d = '0;
        w_lb_clr = 1'b1;
        if (bus.load) w_state_d = StSetup;
      end
      StSetup: begin
        w_addr_d  = w_addr_set;
        w_state_d = StFetch;
      end
      StFetch: begin
        w_lb_load = 1'b1;
        if (r_word == WB'(WORDS - 1)) begin
          w_state_d = StWaitHstart;
        end else begin
          w_word_d  = r_word + 1'b1;
          w_state_d = StSetup;
        end
      end
      StWaitHstart: begin
        if (bus.hstart) w_state_d = StDraw;
      end
      StDraw: begin
        w_lb_step = 1'b1;
        w_gfx_d   = w_pix;
        if (w_last) begin
          if (r_row == RB'(SPRITE_H - 1)) begin
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_row_d   = r_row + 1'b1;
            w_state_d = StWaitLoad;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_row   <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_gfx   <= 1'b0;
      r_done  <= 1'b0;
      r_hm    <= 1'b0;
      r_vm    <= 1'b0;
      r_xs    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_row   <= w_row_d;
      r_word  <= w_word_d;
      r_addr  <= w_addr_d;
      r_gfx   <= w_gfx_d;
      r_done  <= w_done_d;
      if (w_latch) begin
        r_hm <= bus.hmirror;
        r_vm <= bus.vmirror;
        r_xs <= bus.xscale;
      end
    end
  end

  sprite_line_buffer #(
    .SPRITE_W (SPRITE_W),
    .ROM_W    (ROM_W)
  ) u_line_buffer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_lb_load),
    .i_word     (r_word),
    .i_rom_bits (bus.rom_bits),
    .i_clr      (w_lb_clr),
    .i_step     (w_lb_step),
    .i_xscale   (r_xs),
    .i_hmirror  (r_hm),
    .o_pix      (w_pix),
    .o_last     (w_last)
  );

`ifdef SPRITE_RENDERER_COLLIDE_EN
  logic r_coll;

  // A hit in the same clock as a new vstart keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_coll <= 1'b0;
    end else if (r_gfx && bus.playfield) begin
      r_coll <= 1'b1;
    end else if (w_latch) begin
      r_coll <= 1'b0;
    end
  end

  assign bus.collision = r_coll;
`endif

  assign bus.rom_addr = r_addr;
  assign bus.gfx      = r_gfx;
  assign bus.busy     = (r_state != StIdle);
  assign bus.done     = r_done;

endmodule

// File: tb/tb_sprite_renderer_p.sv
// Directed bench for sprite_renderer_p: a 16x16/8-bit instance and a 32x16/8-bit stretched instance.
module tb_sprite_renderer_p;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rom_mode = 0;

  always #5 clk = ~clk;

  sprite_renderer_p_if #(.ADDR_W(5), .ROM_W(8)) if_a ();
  sprite_renderer_p_if #(.ADDR_W(6), .ROM_W(8)) if_b ();

  // Mode 0: identity ROM (data = address); mode 1: word0 = 8'h01, word1 = 8'h00 on every row.
  assign if_a.rom_bits = (rom_mode == 0) ? {3'b000, if_a.rom_addr}
                                         : (if_a.rom_addr[0] ? 8'h00 : 8'h01);
  assign if_b.rom_bits = {2'b00, if_b.rom_addr};

  sprite_renderer_p #(.SPRITE_W(16), .SPRITE_H(16), .ROM_W(8)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  sprite_renderer_p #(.SPRITE_W(32), .SPRITE_H(16), .ROM_W(8)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic a_vstart();
    if_a.vstart = 1'b1;
    tick();
    if_a.vstart = 1'b0;
  endtask

  task automatic a_fetch(output logic [4:0] a0, output logic [4:0] a1);
    if_a.load = 1'b1;
    tick();
    if_a.load = 1'b0;
    tick();
    a0 = if_a.rom_addr;
    tick();
    tick();
    a1 = if_a.rom_addr;
    tick();
  endtask

  task automatic a_draw(output logic [15:0] pix, output logic done_last);
    if_a.hstart = 1'b1;
    tick();
    if_a.hstart = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      pix[i] = if_a.gfx;
      if (i == 15) done_last = if_a.done;
      else tick();
    end
  endtask

  task automatic a_row(input int r, input logic [4:0] ea0, input logic [15:0] epix,
                       input logic last);
    logic [4:0]  a0, a1;
    logic [15:0] pix;
    logic        dn;
    a_fetch(a0, a1);
    check_eq($sformatf("row%0d_addr0", r), a0, ea0);
    check_eq($sformatf("row%0d_addr1", r), a1, ea0 + 5'd1);
    a_draw(pix, dn);
    check_eq($sformatf("row%0d_pixels", r), pix, epix);
    check_eq($sformatf("row%0d_done", r), dn, last);
    tick();
    check_eq($sformatf("row%0d_gfx_after", r), if_a.gfx, 1'b0);
    check_eq($sformatf("row%0d_busy_after", r), if_a.busy, !last);
  endtask

  initial begin
    logic [4:0]  a0, a1;
    logic [15:0] pix;
    logic        dn;
    logic [63:0] line;
    if_a.vstart = 0; if_a.load = 0; if_a.hstart = 0;
    if_a.hmirror = 0; if_a.vmirror = 0; if_a.xscale = 0;
    if_b.vstart = 0; if_b.load = 0; if_b.hstart = 0;
    if_b.hmirror = 0; if_b.vmirror = 0; if_b.xscale = 0;
`ifdef SPRITE_RENDERER_COLLIDE_EN
    if_a.playfield = 0;
    if_b.playfield = 0;
`endif
    tick();
    tick();
    check_eq("reset_gfx", if_a.gfx, 1'b0);
    check_eq("reset_busy", if_a.busy, 1'b0);
    check_eq("reset_done", if_a.done, 1'b0);
    check_eq("reset_addr", if_a.rom_addr, 5'd0);
    reset = 1'b0;
    tick();

    // Full frame, identity ROM: row r shows {2r+1, 2r} LSB first.
    a_vstart();
    check_eq("busy_after_vstart", if_a.busy, 1'b1);
    for (int r = 0; r < 16; r++) begin
      if (r == 3) a_vstart();
      if (r == 4) begin
        if_a.hstart = 1'b1;
        tick();
        if_a.hstart = 1'b0;
      end
      a_row(r, 5'(2 * r), {8'(2 * r + 1), 8'(2 * r)}, r == 15);
    end
    check_eq("done_one_cycle", if_a.done, 1'b0);
    check_eq("row0_hand", 16'h0100, {8'(1), 8'(0)});

    // Vertical mirror latched at vstart; later vmirror changes are ignored.
    if_a.vmirror = 1'b1;
    a_vstart();
    if_a.vmirror = 1'b0;
    a_row(0, 5'b11110, 16'h1F1E, 1'b0);
    if_a.vmirror = 1'b1;
    a_row(1, 5'b11100, 16'h1D1C, 1'b0);
    if_a.vmirror = 1'b0;
    do_reset();

    // Horizontal mirror: only bit 0 set, so it appears on the 16th pixel.
    rom_mode = 1;
    if_a.hmirror = 1'b1;
    a_vstart();
    if_a.hmirror = 1'b0;
    a_row(0, 5'd0, 16'h8000, 1'b0);
    a_row(1, 5'd2, 16'h8000, 1'b0);
    do_reset();
    rom_mode = 0;

    // Reset in the middle of row 7's line, then a clean restart.
    a_vstart();
    for (int r = 0; r < 7; r++) a_row(r, 5'(2 * r), {8'(2 * r + 1), 8'(2 * r)}, 1'b0);
    a_fetch(a0, a1);
    check_eq("row7_addr0", a0, 5'd14);
    if_a.hstart = 1'b1;
    tick();
    if_a.hstart = 1'b0;
    tick();
    tick();
    check_eq("row7_pix1", if_a.gfx, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("abort_gfx", if_a.gfx, 1'b0);
    check_eq("abort_busy", if_a.busy, 1'b0);
    check_eq("abort_addr", if_a.rom_addr, 5'd0);
    tick();
    reset = 1'b0;
    tick();
    a_vstart();
    a_row(0, 5'd0, 16'h0100, 1'b0);
    do_reset();

    // 32-wide sprite, stretched: four fetch pairs, 64-clock line.
    if_b.xscale = 1'b1;
    if_b.vstart = 1'b1;
    tick();
    if_b.vstart = 1'b0;
    if_b.xscale = 1'b0;
    if_b.load = 1'b1;
    tick();
    if_b.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("b_addr%0d", k), if_b.rom_addr, 6'(k));
      tick();
    end
    if_b.hstart = 1'b1;
    tick();
    if_b.hstart = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) begin
      line[i] = if_b.gfx;
      if (i < 63) tick();
    end
    check_eq("b_line", line, 64'h000F_000C_0003_0000);
    tick();
    check_eq("b_gfx_after", if_b.gfx, 1'b0);
    check_eq("b_busy_after", if_b.busy, 1'b1);
    do_reset();

`ifdef SPRITE_RENDERER_COLLIDE_EN
    rom_mode = 1;
    a_vstart();
    a_fetch(a0, a1);
    if_a.hstart = 1'b1;
    tick();
    if_a.hstart = 1'b0;
    if_a.playfield = 1'b1;
    tick();
    check_eq("coll_pf_only", if_a.collision, 1'b0);
    tick();
    if_a.playfield = 1'b0;
    check_eq("coll_set", if_a.collision, 1'b1);
    repeat (15) tick();
    for (int r = 1; r < 16; r++) begin
      a_fetch(a0, a1);
      a_draw(pix, dn);
      tick();
    end
    check_eq("coll_hold", if_a.collision, 1'b1);
    a_vstart();
    check_eq("coll_clear", if_a.collision, 1'b0);
    rom_mode = 0;
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
